param_data_memory: RTL and testbench

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

---
 rtl/param_data_memory.sv | 197 +++++++++++++++++++
 tb/tb_param_data_memory.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
// Byte-addressable data memory with a valid/ready request and response channel.
// Contents are cleared one word per cycle after reset; loads and stores of
// 1/2/4 bytes are range- and alignment-checked, with a one-cycle response.
module param_data_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        MEM_req_valid,
    output logic        MEM_req_ready,
    input  logic        MEM_req_write,
    input  logic [1:0]  MEM_req_length,
    input  logic        MEM_req_signed,
    input  logic [31:0] MEM_req_address,
    input  logic [31:0] MEM_req_wdata,
    output logic        MEM_resp_valid,
    input  logic        MEM_resp_ready,
    output logic [31:0] MEM_resp_data,
    output logic        MEM_resp_error,
    output logic        MEM_init_done
);

    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned CW    = AW - 2;
    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam logic [32:0] LAST_BYTE = 33'(BASE_ADDR) + 33'(DEPTH_BYTES) - 33'd1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   clr_q;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept_c;
    logic [2:0]      nbytes_c;
    logic [32:0]     diff_c;
    logic [32:0]     end_addr_c;
    logic            below_c;
    logic            above_c;
    logic            misalign_c;
    logic            req_err_c;
    logic [AW-1:0]   offset_c;
    logic [AW-1:0]   idx_c [4];
    logic [7:0]      rbyte_c [4];
    logic [31:0]     wshift_c;
    logic [7:0]      wbyte_c [4];
    logic [3:0]      wen_c;
    logic [31:0]     raw_c;
    logic [31:0]     load_c;
    logic            unused_bits_c;

    assign accept_c = MEM_req_valid && MEM_req_ready;

    // Request decode: access size, range and alignment checks
    always_comb begin
        nbytes_c = 3'd0;
        case (MEM_req_length)
            2'b01:   nbytes_c = 3'd1;
            2'b10:   nbytes_c = 3'd2;
            2'b11:   nbytes_c = 3'd4;
            default: nbytes_c = 3'd0;
        endcase
        diff_c     = {1'b0, MEM_req_address} - {1'b0, BASE_ADDR};
        end_addr_c = {1'b0, MEM_req_address} + 33'(nbytes_c) - 33'd1;
        below_c    = diff_c[32];
        above_c    = end_addr_c > LAST_BYTE;
        misalign_c = ALIGN_CHECK &&
                     (((MEM_req_length == 2'b10) && MEM_req_address[0]) ||
                      ((MEM_req_length == 2'b11) && (MEM_req_address[1:0] != 2'b00)));
        req_err_c  = (nbytes_c == 3'd0) || below_c || above_c || misalign_c;
        offset_c   = diff_c[AW-1:0];
    end

    // Upper offset bits only matter through the range check
    assign unused_bits_c = ^diff_c[31:AW];

    // Byte lane addresses, read data and store data per lane
    always_comb begin
        case (nbytes_c)
            3'd1:    wshift_c = {MEM_req_wdata[7:0], 24'h000000};
            3'd2:    wshift_c = {MEM_req_wdata[15:0], 16'h0000};
            default: wshift_c = MEM_req_wdata;
        endcase
        for (int k = 0; k < 4; k++) begin
            idx_c[k]   = offset_c + AW'(k);
            rbyte_c[k] = mem[idx_c[k]];
            wen_c[k]   = (3'(k) < nbytes_c);
            if (BIG_ENDIAN) begin
                wbyte_c[k] = wshift_c[8*(3-k) +: 8];
            end else begin
                wbyte_c[k] = MEM_req_wdata[8*k +: 8];
            end
        end
    end

    // Load result assembly with zero/sign extension
    always_comb begin
        raw_c = 32'h0;
        if (BIG_ENDIAN) begin
            case (nbytes_c)
                3'd1:    raw_c = {24'h0, rbyte_c[0]};
                3'd2:    raw_c = {16'h0, rbyte_c[0], rbyte_c[1]};
                3'd4:    raw_c = {rbyte_c[0], rbyte_c[1], rbyte_c[2], rbyte_c[3]};
                default: raw_c = 32'h0;
            endcase
        end else begin
            case (nbytes_c)
                3'd1:    raw_c = {24'h0, rbyte_c[0]};
                3'd2:    raw_c = {16'h0, rbyte_c[1], rbyte_c[0]};
                3'd4:    raw_c = {rbyte_c[3], rbyte_c[2], rbyte_c[1], rbyte_c[0]};
                default: raw_c = 32'h0;
            endcase
        end
        load_c = raw_c;
        if (MEM_req_signed && (nbytes_c == 3'd1)) begin
            load_c = {{24{raw_c[7]}}, raw_c[7:0]};
        end else if (MEM_req_signed && (nbytes_c == 3'd2)) begin
            load_c = {{16{raw_c[15]}}, raw_c[15:0]};
        end
        if (MEM_req_write || req_err_c) begin
            load_c = 32'h0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clr_q == CW'(WORDS - 1)) state_d = ST_IDLE;
            ST_IDLE: if (accept_c) state_d = ST_RESP;
            ST_RESP: if (MEM_resp_valid && MEM_resp_ready) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // State register and clear counter
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state_q <= ST_INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                clr_q <= clr_q + CW'(1);
            end
        end
    end

    // Registered handshake flags and response payload
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            MEM_req_ready  <= 1'b0;
            MEM_init_done  <= 1'b0;
            MEM_resp_valid <= 1'b0;
            MEM_resp_data  <= 32'h0;
            MEM_resp_error <= 1'b0;
        end else begin
            MEM_req_ready <= (state_d == ST_IDLE);
            MEM_init_done <= (state_d != ST_INIT);
            if (accept_c) begin
                MEM_resp_valid <= 1'b1;
                MEM_resp_data  <= load_c;
                MEM_resp_error <= req_err_c;
            end else if (MEM_resp_valid && MEM_resp_ready) begin
                MEM_resp_valid <= 1'b0;
                MEM_resp_data  <= 32'h0;
                MEM_resp_error <= 1'b0;
            end
        end
    end

    // Storage: INIT zeroes one word per cycle, accepted good stores write their lanes
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            if (state_q == ST_INIT) begin
                mem[{clr_q, 2'd0}] <= 8'h00;
                mem[{clr_q, 2'd1}] <= 8'h00;
                mem[{clr_q, 2'd2}] <= 8'h00;
                mem[{clr_q, 2'd3}] <= 8'h00;
            end else if (accept_c && MEM_req_write && !req_err_c) begin
                if (wen_c[0]) mem[idx_c[0]] <= wbyte_c[0];
                if (wen_c[1]) mem[idx_c[1]] <= wbyte_c[1];
                if (wen_c[2]) mem[idx_c[2]] <= wbyte_c[2];
                if (wen_c[3]) mem[idx_c[3]] <= wbyte_c[3];
            end
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a big-endian aligned instance at base 0 and a
// little-endian unaligned instance at base 0x100 share one request stream and
// are compared against a byte-array reference model.
module tb_param_data_memory;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NWORDS = DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_length;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [1:0]  rdy;
    logic [1:0]  rvalid;
    logic [1:0]  rerr;
    logic [1:0]  idone;
    logic [31:0] rdata [2];

    logic [7:0]  mdl [2][DEPTH];
    logic [31:0] cap_data [2];
    logic        cap_err [2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    param_data_memory #(
        .BASE_ADDR(32'h0000_0000), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b1), .ALIGN_CHECK(1'b1)
    ) dut_be (
        .SYS_clk(clk), .SYS_reset(rst_n),
        .MEM_req_valid(req_valid), .MEM_req_ready(rdy[0]), .MEM_req_write(req_write),
        .MEM_req_length(req_length), .MEM_req_signed(req_signed),
        .MEM_req_address(req_address), .MEM_req_wdata(req_wdata),
        .MEM_resp_valid(rvalid[0]), .MEM_resp_ready(resp_ready),
        .MEM_resp_data(rdata[0]), .MEM_resp_error(rerr[0]), .MEM_init_done(idone[0])
    );

    param_data_memory #(
        .BASE_ADDR(32'h0000_0100), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b0), .ALIGN_CHECK(1'b0)
    ) dut_le (
        .SYS_clk(clk), .SYS_reset(rst_n),
        .MEM_req_valid(req_valid), .MEM_req_ready(rdy[1]), .MEM_req_write(req_write),
        .MEM_req_length(req_length), .MEM_req_signed(req_signed),
        .MEM_req_address(req_address), .MEM_req_wdata(req_wdata),
        .MEM_resp_valid(rvalid[1]), .MEM_resp_ready(resp_ready),
        .MEM_resp_data(rdata[1]), .MEM_resp_error(rerr[1]), .MEM_init_done(idone[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: instance 0 big-endian/aligned/base 0, instance 1 little-endian/unaligned/base 0x100
    task automatic model_apply(input int i, input bit wr, input logic [1:0] len, input bit sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] data, output bit err);
        longint base;
        longint first;
        int     n;
        int     off;
        bit     be;
        bit     al;
        base  = (i == 0) ? 64'd0 : 64'd256;
        be    = (i == 0);
        al    = (i == 0);
        n     = (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : (len == 2'd3) ? 4 : 0;
        first = longint'(addr);
        err   = (n == 0) || (first < base) || (first + n - 1 > base + DEPTH - 1) ||
                (al && n == 2 && addr[0]) || (al && n == 4 && addr[1:0] != 2'b00);
        data  = 32'h0;
        if (err) return;
        off = int'(first - base);
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                mdl[i][off + k] = be ? 8'(wd >> (8 * (n - 1 - k))) : 8'(wd >> (8 * k));
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                if (be) data = (data << 8) | 32'(mdl[i][off + k]);
                else    data = data | (32'(mdl[i][off + k]) << (8 * k));
            end
            if (sgn && n == 1 && data[7])  data = data | 32'hFFFF_FF00;
            if (sgn && n == 2 && data[15]) data = data | 32'hFFFF_0000;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < int'(DEPTH); b++) mdl[i][b] = 8'h00;
        end
    endtask

    // One request to both instances; waits through the handshake when resp_ready is high
    task automatic xact(input string tag, input bit wr, input logic [1:0] len, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] ed;
        bit          ee;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(rdy), 32'h3);
        req_valid   = 1'b1;
        req_write   = wr;
        req_length  = len;
        req_signed  = sgn;
        req_address = addr;
        req_wdata   = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model_apply(i, wr, len, sgn, addr, wd, ed, ee);
            cap_data[i] = rdata[i];
            cap_err[i]  = rerr[i];
            check($sformatf("%s_valid%0d", tag, i), 32'(rvalid[i]), 32'h1);
            check($sformatf("%s_data%0d", tag, i), rdata[i], ed);
            check($sformatf("%s_err%0d", tag, i), 32'(rerr[i]), 32'(ee));
        end
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts cycles from reset release until the request channel opens
    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (rdy[0] !== 1'b1 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_init_cycles"}, 32'(cnt), 32'(NWORDS));
        check({tag, "_init_done"}, 32'(idone), 32'h3);
        check({tag, "_ready_both"}, 32'(rdy), 32'h3);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] hold [2];
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_length  = 2'b00;
        req_signed  = 1'b0;
        req_address = 32'h0;
        req_wdata   = 32'h0;
        resp_ready  = 1'b1;
        clear_model();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy), 32'h0);
        check("rst_valid", 32'(rvalid), 32'h0);
        check("rst_err", 32'(rerr), 32'h0);
        check("rst_init_done", 32'(idone), 32'h0);
        check("rst_data0", rdata[0], 32'h0);
        check("rst_data1", rdata[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("boot");

        // Misaligned word store is rejected and leaves memory untouched
        xact("st_w_mis", 1'b1, 2'b11, 1'b0, 32'h2, 32'h1234_5678);
        check("st_w_mis_err", 32'(cap_err[0]), 32'h1);
        xact("ld_w0", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check("ld_w0_zero", cap_data[0], 32'h0);
        xact("ld_w_end", 1'b0, 2'b11, 1'b0, DEPTH - 2, 32'h0);
        check("ld_w_end_err", 32'(cap_err[0]), 32'h1);
        check("ld_w_end_data", cap_data[0], 32'h0);
        xact("ld_w_last", 1'b0, 2'b11, 1'b0, DEPTH - 4, 32'h0);
        xact("ld_w_le_end", 1'b0, 2'b11, 1'b0, 32'h100 + DEPTH - 2, 32'h0);
        check("ld_w_le_end_err", 32'(cap_err[1]), 32'h1);
        xact("ld_len0", 1'b0, 2'b00, 1'b0, 32'h110, 32'h0);
        check("ld_len0_err", 32'(cap_err[1]), 32'h1);

        // Endianness of byte loads after a word store
        xact("st_dead_be", 1'b1, 2'b11, 1'b0, 32'h8, 32'hDEAD_BEEF);
        xact("ld_b_be", 1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
        check("ld_b_be_val", cap_data[0], 32'h0000_00DE);
        xact("st_dead_le", 1'b1, 2'b11, 1'b0, 32'h108, 32'hDEAD_BEEF);
        xact("ld_b_le", 1'b0, 2'b01, 1'b0, 32'h108, 32'h0);
        check("ld_b_le_val", cap_data[1], 32'h0000_00EF);
        check("ld_b_le_below", 32'(cap_err[1]), 32'h0);

        // Half store with signed/unsigned loads and a word read-back
        xact("st_h", 1'b1, 2'b10, 1'b0, 32'h2, 32'h0000_8001);
        xact("ld_hs", 1'b0, 2'b10, 1'b1, 32'h2, 32'h0);
        check("ld_hs_val", cap_data[0], 32'hFFFF_8001);
        xact("ld_hu", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        check("ld_hu_val", cap_data[0], 32'h0000_8001);
        xact("ld_w", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check("ld_w_val", cap_data[0], 32'h0000_8001);

        // Randomized traffic, including addresses near the top of the space
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 15) == 0) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                            addr = 32'($urandom_range(0, 32'h520));
            xact("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), addr, $urandom);
        end

        // Response held stable while the consumer stalls
        resp_ready = 1'b0;
        xact("stall", 1'b0, 2'b11, 1'b0, 32'h108, 32'h0);
        hold[0] = cap_data[0];
        hold[1] = cap_data[1];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(rvalid), 32'h3);
            check("stall_data0", rdata[0], hold[0]);
            check("stall_data1", rdata[1], hold[1]);
            check("stall_ready", 32'(rdy), 32'h0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("unstall_valid", 32'(rvalid), 32'h0);
        check("unstall_ready", 32'(rdy), 32'h3);

        // Reset while a response is pending discards it and wipes memory
        xact("pre_st_be", 1'b1, 2'b11, 1'b0, 32'h40, 32'h1122_3344);
        xact("pre_st_le", 1'b1, 2'b11, 1'b0, 32'h140, 32'h5566_7788);
        resp_ready = 1'b0;
        xact("pre_ld", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        check("pre_ld_val", cap_data[0], 32'h1122_3344);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(rvalid), 32'h0);
        check("rst_resp_ready", 32'(rdy), 32'h0);
        check("rst_resp_done", 32'(idone), 32'h0);
        check("rst_resp_data", rdata[0], 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        clear_model();
        wait_init("reinit");
        xact("post_ld_be", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        check("post_ld_be_val", cap_data[0], 32'h0);
        xact("post_ld_le", 1'b0, 2'b11, 1'b0, 32'h140, 32'h0);
        check("post_ld_le_val", cap_data[1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
